alu_seq: RTL and testbench

Parametrised, handshaked successor to the single-cycle datapath ALU. Adds XOR/shift/signed-compare, plus iterative unsigned multiply and divide. Registers operands and produces a registered result with a Zero flag over a valid/ready interface. Sits in the execute stage and stalls the pipeline through `in_ready` while a multi-cycle operation is in flight.

---
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked execute-stage ALU. Single-cycle logic/arith/shift/
//            compare ops plus iterative unsigned MUL/MULHU/DIVU/REMU with a
//            registered result and Zero flag over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] imm,
  input  logic            ALUSrc,
  input  logic [3:0]      operation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_result,
  output logic            Zero,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] c_OP_AND   = 4'b0000;
  localparam logic [3:0] c_OP_OR    = 4'b0001;
  localparam logic [3:0] c_OP_ADD   = 4'b0010;
  localparam logic [3:0] c_OP_XOR   = 4'b0011;
  localparam logic [3:0] c_OP_SLL   = 4'b0100;
  localparam logic [3:0] c_OP_SRL   = 4'b0101;
  localparam logic [3:0] c_OP_SUB   = 4'b0110;
  localparam logic [3:0] c_OP_SLTU  = 4'b0111;
  localparam logic [3:0] c_OP_SLT   = 4'b1000;
  localparam logic [3:0] c_OP_SRA   = 4'b1001;
  localparam logic [3:0] c_OP_MULHU = 4'b1011;
  localparam logic [3:0] c_OP_DIVU  = 4'b1100;
  localparam logic [3:0] c_OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [XLEN-1:0]   r_b;        // latched operand B (multiplicand / divisor)
  logic [3:0]        r_op;       // latched opcode for the iterative unit
  logic [CNT_W-1:0]  r_cnt;      // remaining iteration steps
  logic [2*XLEN-1:0] r_prod;     // MUL: {hi, lo}; DIV: lo holds dividend -> quotient
  logic [XLEN-1:0]   r_rem;      // restoring-divide partial remainder (always < B)
  logic [XLEN-1:0]   r_result;
  logic              r_zero;

  logic              w_accept;
  logic [XLEN-1:0]   w_b;
  logic [SH_W-1:0]   w_shamt;
  logic              w_iter;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_prod_nxt;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN+1:0]   w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_iter_res;
  logic              w_unused_diff_msb;

  assign in_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_b        = ALUSrc ? imm : data2;
  assign w_shamt    = w_b[SH_W-1:0];
  // MUL/MULHU are 101x, DIVU/REMU are 110x
  assign w_iter     = operation[3] & (operation[2] ^ operation[1]);
  assign ALU_result = r_result;
  assign Zero       = r_zero;

  // Shift-add multiply step: conditionally add B into the high half, then shift right
  assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_prod_nxt = {w_mul_sum, r_prod[XLEN-1:1]};

  // Restoring divide step: bring in next dividend bit, subtract divisor if it fits.
  // A zero divisor always "fits", giving all-ones quotient and remainder = A.
  assign w_rem_sh   = {r_rem, r_prod[XLEN-1]};
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
  assign w_ge       = ~w_diff[XLEN+1];
  assign w_rem_nxt  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt  = {r_prod[XLEN-2:0], w_ge};
  // bit XLEN of the difference is zero whenever it is kept, so it is never stored
  assign w_unused_diff_msb = w_diff[XLEN];

  // Single-cycle result from the operands presented with the request
  always_comb begin
    w_alu = '0;
    case (operation)
      c_OP_AND:  w_alu = data1 & w_b;
      c_OP_OR:   w_alu = data1 | w_b;
      c_OP_ADD:  w_alu = data1 + w_b;
      c_OP_SUB:  w_alu = data1 - w_b;
      c_OP_XOR:  w_alu = data1 ^ w_b;
      c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (data1 < w_b)};
      c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(w_b))};
      c_OP_SLL:  w_alu = data1 << w_shamt;
      c_OP_SRL:  w_alu = data1 >> w_shamt;
      c_OP_SRA:  w_alu = $signed(data1) >>> w_shamt;
      default:   w_alu = '0;
    endcase
  end

  // Select which view of the final iteration becomes the result
  always_comb begin
    w_iter_res = w_prod_nxt[XLEN-1:0];
    case (r_op)
      c_OP_MULHU: w_iter_res = w_prod_nxt[2*XLEN-1:XLEN];
      c_OP_DIVU:  w_iter_res = w_quo_nxt;
      c_OP_REMU:  w_iter_res = w_rem_nxt;
      default:    w_iter_res = w_prod_nxt[XLEN-1:0];
    endcase
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_iter ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (w_accept)       w_state_nxt = w_iter ? S_BUSY : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept) begin
      r_b  <= w_b;
      r_op <= operation;
      if (w_iter) begin
        r_cnt  <= CNT_W'(XLEN);
        r_prod <= {{XLEN{1'b0}}, data1};
        r_rem  <= '0;
      end else begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_op[2]) begin
        r_prod <= {r_prod[2*XLEN-1:XLEN], w_quo_nxt};
        r_rem  <= w_rem_nxt;
      end else begin
        r_prod <= w_prod_nxt;
      end
      if (r_cnt == CNT_W'(1)) begin
        r_result <= w_iter_res;
        r_zero   <= (w_iter_res == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench for alu_seq with an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] data1 = '0;
  logic [XLEN-1:0] data2 = '0;
  logic [XLEN-1:0] imm = '0;
  logic            ALUSrc = 1'b0;
  logic [3:0]      operation = 4'h0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] ALU_result;
  logic            Zero;
  logic            busy;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data1      (data1),
    .data2      (data2),
    .imm        (imm),
    .ALUSrc     (ALUSrc),
    .operation  (operation),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALU_result (ALU_result),
    .Zero       (Zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          busy_cnt = 0;
  bit          fresh = 1'b1;
  bit          dir_use = 1'b0;
  logic [31:0] dir_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_iter(input logic [3:0] op);
    return (op == 4'hA) || (op == 4'hB) || (op == 4'hC) || (op == 4'hD);
  endfunction

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h3: r = a ^ b;
      4'h4: r = a << b[4:0];
      4'h5: r = a >> b[4:0];
      4'h6: r = a - b;
      4'h7: r = (a < b) ? 32'd1 : 32'd0;
      4'h8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: r = $signed(a) >>> b[4:0];
      4'hA: r = p[31:0];
      4'hB: r = p[63:32];
      4'hC: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hD: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      fresh = 1'b1;
    end else begin
      if (busy) begin
        check("in_ready_in_busy", {31'd0, in_ready}, 32'd0);
        busy_cnt++;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb[0];
          if (fresh) begin
            check("latency", cyc - e.acc, e.lat);
            if (e.lat > 1) check("busy_cycles", busy_cnt, XLEN);
          end
          if (out_ready) begin
            check("result", ALU_result, e.res);
            check("zero", {31'd0, Zero}, {31'd0, (e.res == 32'd0)});
            void'(sb.pop_front());
          end else begin
            check("hold_result", ALU_result, e.res);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
          end
        end
        fresh = out_ready;
      end else begin
        fresh = 1'b1;
      end
      if (in_valid && in_ready) begin
        e.res = dir_use ? dir_exp : model(operation, data1, ALUSrc ? imm : data2);
        e.lat = is_iter(operation) ? XLEN + 1 : 1;
        e.acc = cyc;
        sb.push_back(e);
        busy_cnt = 0;
        dir_use  = 1'b0;
      end
    end
  end

  // Present a request (called just after a rising edge) and hold it until accepted
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [31:0] ex, input bit use_ex);
    int n;
    operation = op;
    data1     = a;
    ALUSrc    = src;
    if (src) begin imm = b; data2 = $urandom; end
    else     begin data2 = b; imm = $urandom; end
    dir_exp  = ex;
    dir_use  = use_ex;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    data1     = $urandom;
    data2     = $urandom;
    imm       = $urandom;
    operation = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || out_valid) && n < 100);
    if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_result"},    ALU_result, 32'd0);
    check({tag, "_zero"},      {31'd0, Zero}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Basic arithmetic through both B sources
    do_op(4'h2, 32'd5, 32'd7, 1'b0, 32'd12, 1'b1); idle(); drain();
    do_op(4'h6, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1);  idle(); drain();
    do_op(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'h00F0_1234, 1'b1); idle(); drain();
    do_op(4'h1, 32'hF000_0001, 32'h0000_0010, 1'b1, 32'hF000_0011, 1'b1); idle(); drain();
    do_op(4'h3, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 32'h5555_5555, 1'b1); idle(); drain();

    // Compares and shifts
    do_op(4'h8, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 1'b1); idle(); drain();
    do_op(4'h7, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1); idle(); drain();
    do_op(4'h9, 32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF, 1'b1); idle(); drain();
    do_op(4'h5, 32'h8000_0000, 32'd31, 1'b0, 32'd1, 1'b1); idle(); drain();
    do_op(4'h4, 32'd3, 32'd33, 1'b0, 32'd6, 1'b1); idle(); drain();
    do_op(4'hE, 32'd3, 32'd4, 1'b0, 32'd0, 1'b1); idle(); drain();
    do_op(4'hF, 32'd3, 32'd4, 1'b0, 32'd0, 1'b1); idle(); drain();

    // Iterative multiply, second request waits for the first to complete
    do_op(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b1);
    do_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b1);
    idle(); drain();

    // Divide, including divide by zero
    do_op(4'hC, 32'd100, 32'd7, 1'b0, 32'd14, 1'b1); idle(); drain();
    do_op(4'hD, 32'd100, 32'd7, 1'b1, 32'd2, 1'b1);  idle(); drain();
    do_op(4'hC, 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b1); idle(); drain();
    do_op(4'hD, 32'h1234, 32'd0, 1'b0, 32'h0000_1234, 1'b1); idle(); drain();

    // Backpressure: result held for several cycles in DONE
    out_ready = 1'b0;
    do_op(4'h2, 32'd40, 32'd2, 1'b0, 32'd42, 1'b1); idle();
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back single-cycle ops, one per cycle
    for (int i = 0; i < 6; i++) begin
      do_op(4'h2, 32'(i * 3), 32'(i + 100), 1'b0, 32'(i * 4 + 100), 1'b1);
    end
    idle(); drain();

    // Random mix checked against the reference model
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      do_op(op, a, b, 1'($urandom_range(0, 1)), 32'd0, 1'b0);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle(); drain();

    // Abort a divide mid-flight with reset
    do_op(4'h2, 32'd1, 32'd1, 1'b0, 32'd2, 1'b1); idle(); drain();
    do_op(4'hC, 32'd100, 32'd7, 1'b0, 32'd14, 1'b1); idle();
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (busy) n++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("abort");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Recovery after abort
    do_op(4'h6, 32'd50, 32'd8, 1'b1, 32'd42, 1'b1); idle(); drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
